i2s_rx_deser: RTL and testbench
===============================

# i2s_rx_deser

I2S receive deserializer that sits directly upstream of the slow-to-fast CDC stage. It runs entirely in the I2S bit-clock domain (1.4112 MHz; 44.1 kHz × 2 channels × 16-bit slots). It samples the serial data and word-select lines and emits one parallel audio packet per channel slot, with a one-cycle valid pulse. Its packet and valid outputs connect directly to the CDC packet and valid inputs.

## Interface
- PKT_WIDTH, 16: bits per emitted packet; also the number of bits captured per slot.
- CHAN_MASK, 2'b11: bit0 enables left-slot emission, bit1 enables right-slot emission.
- clkI2SBit_i  input  1  I2S bit clock; all logic on its rising edge.
- rstI2S_i  input  1  reset, synchronous, active-high.
- sdI2S_i  input  1  serial data, MSB first.
- wsI2S_i  input  1  word select; 0 = left slot, 1 = right slot.
- pktI2S_o  output  PKT_WIDTH  last captured packet, held between valids.
- pktValidI2S_o  output  1  one-cycle pulse: pktI2S_o is new.
- pktRightI2S_o  output  1  channel tag of pktI2S_o; 1 = right.
- frameErrI2S_o  output  1  only with I2S_FRAME_ERR_EN; one-cycle pulse per short slot.
- errCntI2S_o  output  8  only with I2S_FRAME_ERR_EN; saturating count of short slots.

## Operation
- Register wsQ holds the previous wsI2S_i sample. A WS edge is the condition wsI2S_i != wsQ at a rising edge.
- FSM states:
  - SYNC: entered on reset. Ignore data. On a WS edge go to SHIFT with bitCnt = 0 and chan = wsI2S_i.
  - SHIFT: each edge, shift sdI2S_i into shiftReg (left shift) and increment bitCnt. The first bit is sampled on the edge after the WS edge (standard I2S one-bit delay).
  - DONE: entered when bitCnt reaches PKT_WIDTH. Ignore all further bits until the next WS edge.
- Emission: on the edge that samples the PKT_WIDTH-th bit, and only if CHAN_MASK[chan] = 1:
  - pktI2S_o <= {shiftReg[PKT_WIDTH-2:0], sdI2S_i}
  - pktRightI2S_o <= chan
  - pktValidI2S_o <= 1 for exactly one cycle.
- Simultaneous LSB and WS edge (the normal 16-bit-slot case): capture and emit the completing packet, and in the same edge restart the counter to 0 with the new chan. No bit is lost.
- Short slot (WS edge while in SHIFT with bitCnt < PKT_WIDTH): discard the partial word and emit nothing. Restart for the new slot.
- Long slot (more than PKT_WIDTH bit periods): the top PKT_WIDTH bits are emitted; the rest are dropped in DONE.
- A masked channel still runs the FSM but never pulses valid.
- Reset mid-slot: the partial word is discarded. After release, the FSM waits in SYNC for a WS edge, so the first partial slot is never emitted.

## Timing
- Reset values: pktI2S_o = 0, pktValidI2S_o = 0, pktRightI2S_o = 0, frameErrI2S_o = 0, errCntI2S_o = 0, wsQ = 0, state = SYNC.
- Latency: with the WS edge seen at edge k, the MSB is sampled at k+1 and the LSB at k+PKT_WIDTH. pktValidI2S_o is high from edge k+PKT_WIDTH to edge k+PKT_WIDTH+1.
- pktI2S_o and pktRightI2S_o are stable for at least one full slot after each valid.
- Valid pulses are spaced at least PKT_WIDTH cycles apart. No back-pressure: the downstream stage must accept every pulse.
- Reset asserted on the same edge as an emission: reset wins and no valid is produced.

## Configuration
- I2S_FRAME_ERR_EN defined:
  - frameErrI2S_o pulses one cycle on the edge that detects a short slot.
  - errCntI2S_o increments on the same edge and saturates at 8'hFF.
  - A WS edge seen while in SYNC is not an error.
- I2S_FRAME_ERR_EN undefined: both ports and their logic are absent, and short slots are dropped silently.

## Structure
- Package i2s_pkg: PKT_WIDTH default constant, FSM state enum typedef (SYNC/SHIFT/DONE), channel enum typedef (LEFT = 0, RIGHT = 1), pkt_t typedef.
- Sub-module i2s_ws_edge: holds the wsQ register and outputs wsEdge and the current channel. It shares the same clock and reset.

## Test plan
- Reset, then stereo frames with left 16'hAAAA and right 16'h5555 -> alternating valids: pktI2S_o = AAAA with pktRightI2S_o = 0, then 5555 with pktRightI2S_o = 1. Each valid lands exactly 16 cycles after its WS edge.
- Back-to-back 16-bit slots carrying 16'h0001, 16'h0010, 16'h0100, 16'h1000 -> four valids spaced 16 cycles apart, values exact, no dropped LSB at the slot boundaries.
- Left slot truncated to 10 bits, then right slot 16'h1234 -> no left valid, right valid = 1234. With the macro: frameErrI2S_o pulses once and errCntI2S_o = 1.
- 20-bit slot carrying 20'hABCDE -> pktI2S_o = 16'hABCD; the trailing 4 bits are ignored.
- CHAN_MASK = 2'b01 with left 16'hBEEF and right 16'hCAFE -> only BEEF is emitted with pktRightI2S_o = 0; no valid ever occurs in right slots.
- rstI2S_i asserted for 2 cycles at bit 8 of a slot -> all outputs return to 0. No valid until the first complete slot after the next WS edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive deserializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2s_pkg;

  // Default slot/packet width: 16-bit stereo slots at 1.4112 MHz bit clock.
  localparam int PKT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } i2s_state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_chan_e;

  typedef logic [PKT_WIDTH_DEF-1:0] pkt_t;

endpackage

// File: rtl/i2s_ws_edge.sv
// Word-select edge detector: registers WS and flags any change.
// Latency: combinational edge flag against the WS sample from the previous bit clock.
// Backpressure: none; runs every bit clock.
module i2s_ws_edge
  import i2s_pkg::*;
(
  input  logic      clkI2SBit_i,
  input  logic      rstI2S_i,
  input  logic      wsI2S_i,
  output logic      wsEdge_o,
  output i2s_chan_e chan_o
);

  logic ws_q;

  // Remember previous WS sample; reset to 0 so a high WS right after reset reads as an edge.
  always_ff @(posedge clkI2SBit_i) begin
    if (rstI2S_i) ws_q <= 1'b0;
    else          ws_q <= wsI2S_i;
  end

  assign wsEdge_o = wsI2S_i ^ ws_q;
  assign chan_o   = i2s_chan_e'(wsI2S_i);

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receive deserializer: one parallel packet per enabled channel slot (optional I2S_FRAME_ERR_EN adds short-slot error pulse/count).
// Latency: valid rises PKT_WIDTH bit clocks after the WS edge that opens the slot.
// Backpressure: none; every one-cycle valid must be taken by the downstream CDC stage.
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int         PKT_WIDTH = PKT_WIDTH_DEF,
  parameter logic [1:0] CHAN_MASK = 2'b11
) (
  input  logic                 clkI2SBit_i,
  input  logic                 rstI2S_i,
  input  logic                 sdI2S_i,
  input  logic                 wsI2S_i,
  output logic [PKT_WIDTH-1:0] pktI2S_o,
  output logic                 pktValidI2S_o,
  output logic                 pktRightI2S_o
`ifdef I2S_FRAME_ERR_EN
  ,
  output logic                 frameErrI2S_o,
  output logic [7:0]           errCntI2S_o
`endif
);

  localparam int             CNT_W    = $clog2(PKT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PKT_WIDTH - 1);

  logic      ws_edge;
  i2s_chan_e chan_in;

  i2s_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  i2s_chan_e              chan_q, chan_d;
  // Only PKT_WIDTH-1 history bits are needed: the final bit comes straight from sdI2S_i.
  logic [PKT_WIDTH-2:0]   shift_q, shift_d;
  logic [PKT_WIDTH-1:0]   pkt_q, pkt_d;
  logic                   vld_q, vld_d;
  logic                   right_q, right_d;

  i2s_ws_edge u_ws_edge (
    .clkI2SBit_i (clkI2SBit_i),
    .rstI2S_i    (rstI2S_i),
    .wsI2S_i     (wsI2S_i),
    .wsEdge_o    (ws_edge),
    .chan_o      (chan_in)
  );

  // Slot FSM: shift bits, emit on the last bit, and let a WS edge restart a slot in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    shift_d = shift_q;
    pkt_d   = pkt_q;
    vld_d   = 1'b0;
    right_d = right_q;
    case (state_q)
      SYNC: begin
        if (ws_edge) begin
          state_d = SHIFT;
          cnt_d   = '0;
          chan_d  = chan_in;
        end
      end
      SHIFT: begin
        shift_d = {shift_q[PKT_WIDTH-3:0], sdI2S_i};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          if (CHAN_MASK[chan_q]) begin
            pkt_d   = {shift_q, sdI2S_i};
            right_d = chan_q;
            vld_d   = 1'b1;
          end
          state_d = DONE;
        end
        // A WS edge always opens a new slot; a partial word is simply abandoned.
        if (ws_edge) begin
          state_d = SHIFT;
          cnt_d   = '0;
          chan_d  = chan_in;
        end
      end
      DONE: begin
        if (ws_edge) begin
          state_d = SHIFT;
          cnt_d   = '0;
          chan_d  = chan_in;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State and output registers; synchronous reset overrides any emission on the same edge.
  always_ff @(posedge clkI2SBit_i) begin
    if (rstI2S_i) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      chan_q  <= LEFT;
      shift_q <= '0;
      pkt_q   <= '0;
      vld_q   <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      shift_q <= shift_d;
      pkt_q   <= pkt_d;
      vld_q   <= vld_d;
      right_q <= right_d;
    end
  end

  assign pktI2S_o      = pkt_q;
  assign pktValidI2S_o = vld_q;
  assign pktRightI2S_o = right_q;

`ifdef I2S_FRAME_ERR_EN
  logic       short_slot;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Short slot: WS moves before the last bit of a slot being shifted (edges from SYNC/DONE are fine).
  assign short_slot = (state_q == SHIFT) && ws_edge && (cnt_q != LAST_BIT);

  // Error pulse and saturating error count next-state.
  always_comb begin
    err_d     = short_slot;
    err_cnt_d = err_cnt_q;
    if (short_slot && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error registers.
  always_ff @(posedge clkI2SBit_i) begin
    if (rstI2S_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign frameErrI2S_o = err_q;
  assign errCntI2S_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Testbench for i2s_rx_deser: two instances (all channels, left only) on shared random/directed I2S streams.
// Latency: reference model predicts outputs cycle by cycle from slot boundaries.
// Backpressure: none.
module tb_i2s_rx_deser;
  import i2s_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, ws, sd;
  logic [W-1:0] pkt_a, pkt_b;
  logic         vld_a, vld_b, right_a, right_b;
`ifdef I2S_FRAME_ERR_EN
  logic         err_a, err_b;
  logic [7:0]   cnt_a, cnt_b;
`endif

  i2s_rx_deser #(.PKT_WIDTH(W), .CHAN_MASK(2'b11)) dut_a (
    .clkI2SBit_i   (clk),
    .rstI2S_i      (rst),
    .sdI2S_i       (sd),
    .wsI2S_i       (ws),
    .pktI2S_o      (pkt_a),
    .pktValidI2S_o (vld_a),
    .pktRightI2S_o (right_a)
`ifdef I2S_FRAME_ERR_EN
    ,
    .frameErrI2S_o (err_a),
    .errCntI2S_o   (cnt_a)
`endif
  );

  i2s_rx_deser #(.PKT_WIDTH(W), .CHAN_MASK(2'b01)) dut_b (
    .clkI2SBit_i   (clk),
    .rstI2S_i      (rst),
    .sdI2S_i       (sd),
    .wsI2S_i       (ws),
    .pktI2S_o      (pkt_b),
    .pktValidI2S_o (vld_b),
    .pktRightI2S_o (right_b)
`ifdef I2S_FRAME_ERR_EN
    ,
    .frameErrI2S_o (err_b),
    .errCntI2S_o   (cnt_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus streams, one entry per bit clock. sd_s holds slot bits aligned to the slot's
  // WS cycles; they are driven one cycle later to model the I2S one-bit delay.
  bit ws_s[$];
  bit sd_s[$];
  bit rst_s[$];

  task automatic add_slot(input bit v, input logic [31:0] data, input int nbits,
                          input int len, input int rst_at);
    for (int j = 0; j < len; j++) begin
      ws_s.push_back(v);
      sd_s.push_back((j < nbits) ? data[nbits-1-j] : 1'($urandom));
      rst_s.push_back((rst_at >= 0) && (j == rst_at || j == rst_at + 1));
    end
  endtask

  function automatic bit sd_at(input int i);
    return (i == 0) ? 1'b0 : sd_s[i-1];
  endfunction

  // Reference model state
  bit           m_prev_ws;
  int           m_last_edge;
  logic [W-1:0] m_pkt   [2];
  bit           m_right [2];
  bit           m_vld   [2];
  bit           m_err;
  int           m_cnt;
  logic [1:0]   m_mask  [2];
  logic [W-1:0] word;
  bit           ch;
  int           n_emit_model, n_emit_dut;
  bit           cur;

  initial begin
    m_mask[0] = 2'b11;
    m_mask[1] = 2'b01;

    // Initial reset
    for (int j = 0; j < 3; j++) begin
      ws_s.push_back(1'b0); sd_s.push_back(1'b0); rst_s.push_back(1'b1);
    end
    add_slot(1'b0, 32'h0, 0, 4, -1);              // idle, no WS edge
    add_slot(1'b1, $urandom, 16, 16, -1);         // first slot out of SYNC
    add_slot(1'b0, 32'hAAAA, 16, 16, -1);
    add_slot(1'b1, 32'h5555, 16, 16, -1);
    add_slot(1'b0, 32'hAAAA, 16, 16, -1);
    add_slot(1'b1, 32'h5555, 16, 16, -1);
    add_slot(1'b0, 32'h0001, 16, 16, -1);         // back-to-back single-bit walkers
    add_slot(1'b1, 32'h0010, 16, 16, -1);
    add_slot(1'b0, 32'h0100, 16, 16, -1);
    add_slot(1'b1, 32'h1000, 16, 16, -1);
    add_slot(1'b0, $urandom, 10, 10, -1);         // short left slot
    add_slot(1'b1, 32'h1234, 16, 16, -1);
    add_slot(1'b0, 32'hABCDE, 20, 20, -1);        // long slot
    add_slot(1'b1, $urandom, 16, 16, -1);
    add_slot(1'b0, 32'hBEEF, 16, 16, -1);
    add_slot(1'b1, 32'hCAFE, 16, 16, -1);
    add_slot(1'b0, $urandom, 16, 16, 8);          // reset for 2 cycles at bit 8
    add_slot(1'b1, $urandom, 16, 16, -1);
    add_slot(1'b0, $urandom, 16, 16, -1);
    add_slot(1'b1, $urandom, 20, 20, 16);         // reset on the emission edge
    add_slot(1'b0, $urandom, 16, 16, -1);

    cur = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int len;
      int ra;
      len = $urandom_range(6, 22);
      ra  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      add_slot(cur, $urandom, 32, len, ra);
      cur = ~cur;
    end
`ifdef I2S_FRAME_ERR_EN
    // Drive the error counter into saturation with runs of short slots.
    for (int s = 0; s < 270; s++) begin
      add_slot(cur, $urandom, 2, 2, -1);
      cur = ~cur;
    end
`endif
    add_slot(cur, $urandom, 16, 16, -1);
    cur = ~cur;
    add_slot(cur, $urandom, 16, 16, -1);
    add_slot(cur, 32'h0, 0, 20, -1);              // trailing hold, lets final slot complete

    rst = 1'b1; ws = 1'b0; sd = 1'b0;
    m_prev_ws = 1'b0; m_last_edge = -1; m_cnt = 0;
    n_emit_model = 0; n_emit_dut = 0;
    for (int k = 0; k < 2; k++) begin m_pkt[k] = '0; m_right[k] = 1'b0; end

    for (int t = 0; t < ws_s.size(); t++) begin
      @(negedge clk);
      rst = rst_s[t];
      ws  = ws_s[t];
      sd  = sd_at(t);
      @(posedge clk);
      #1;

      // Model: a slot opens on a WS edge at cycle e and carries the bits sampled at e+1..;
      // it completes W cycles after e unless reset intervenes first.
      m_vld[0] = 1'b0; m_vld[1] = 1'b0; m_err = 1'b0;
      if (rst) begin
        m_prev_ws = 1'b0; m_last_edge = -1; m_cnt = 0;
        for (int k = 0; k < 2; k++) begin m_pkt[k] = '0; m_right[k] = 1'b0; end
      end else begin
        if (m_last_edge >= 0 && t - m_last_edge == W) begin
          for (int i = 0; i < W; i++) word[W-1-i] = sd_at(m_last_edge + 1 + i);
          ch = ws_s[m_last_edge];
          for (int k = 0; k < 2; k++) begin
            if (m_mask[k][ch]) begin
              m_pkt[k] = word; m_right[k] = ch; m_vld[k] = 1'b1;
            end
          end
        end
        if (ws != m_prev_ws) begin
          if (m_last_edge >= 0 && t - m_last_edge < W) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
          m_last_edge = t;
        end
        m_prev_ws = ws;
      end
      if (m_vld[0]) n_emit_model++;
      if (vld_a === 1'b1) n_emit_dut++;

      check_eq($sformatf("vld_a@%0d", t),   32'(vld_a),   32'(m_vld[0]));
      check_eq($sformatf("pkt_a@%0d", t),   32'(pkt_a),   32'(m_pkt[0]));
      check_eq($sformatf("right_a@%0d", t), 32'(right_a), 32'(m_right[0]));
      check_eq($sformatf("vld_b@%0d", t),   32'(vld_b),   32'(m_vld[1]));
      check_eq($sformatf("pkt_b@%0d", t),   32'(pkt_b),   32'(m_pkt[1]));
      check_eq($sformatf("right_b@%0d", t), 32'(right_b), 32'(m_right[1]));
`ifdef I2S_FRAME_ERR_EN
      check_eq($sformatf("err_a@%0d", t),   32'(err_a),   32'(m_err));
      check_eq($sformatf("cnt_a@%0d", t),   32'(cnt_a),   32'(m_cnt));
      check_eq($sformatf("err_b@%0d", t),   32'(err_b),   32'(m_err));
      check_eq($sformatf("cnt_b@%0d", t),   32'(cnt_b),   32'(m_cnt));
`endif
    end

    check_eq("emit_count_a", 32'(n_emit_dut), 32'(n_emit_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
